// File: rtl/popcount_frame_scheduler.sv
// Two-requester round-robin scheduler feeding 4-word frames through a weighted
// popcount accumulator; one tagged result is returned per frame.

module number_of_ones (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o_count = o_count + 5'(i_data[i]);
    end
  end
endmodule

module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is expanded independently from generate/propagate terms so no
  // carry depends on a previously computed carry signal.
  always_comb begin
    logic v_carry;
    v_carry = 1'b0;
    w_c     = '0;
    w_c[0]  = i_cin;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      v_carry = i_cin;
      for (int unsigned j = 0; j < i; j++) begin
        v_carry = w_g[j] | (w_p[j] & v_carry);
      end
      w_c[i] = v_carry;
    end
  end

  assign o_sum = w_p ^ w_c;
endmodule

module popcount_frame_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_data,
  output logic             req1_ready,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_RESULT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       r_idx;
  logic [1:0]       r_word_idx;
  logic [15:0]      r_word;
  logic             r_word_vld;
  logic             r_last;
  logic             r_res_id;
  logic [WIDTH-1:0] r_acc;

  logic             w_any_req;
  logic             w_pick1;
  logic             w_beat;
  logic [15:0]      w_in_data;
  logic [4:0]       w_ones;
  logic [7:0]       w_term;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;

  assign w_any_req = req0_valid | req1_valid;
  // On a tie the requester not served last wins.
  assign w_pick1   = req1_valid & (~req0_valid | ~r_last);
  assign w_beat    = (r_state == S_RUN) &
                     ((r_grant[0] & req0_valid) | (r_grant[1] & req1_valid));
  assign w_in_data = r_grant[1] ? req1_data : req0_data;

  number_of_ones u_ones (
    .i_data  (r_word),
    .o_count (w_ones)
  );

  assign w_term   = {3'b000, w_ones} << r_word_idx;
  assign w_addend = WIDTH'(w_term);

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_RUN;
      S_RUN:    if (w_beat && (r_idx == 2'd3)) w_state_nxt = S_FLUSH;
      S_FLUSH:  w_state_nxt = S_RESULT;
      S_RESULT: if (res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
      r_last     <= 1'b1;
      r_res_id   <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_vld <= w_beat;
      if (w_beat) begin
        r_word     <= w_in_data;
        r_word_idx <= r_idx;
        r_idx      <= r_idx + 2'd1;
      end
      if (r_state == S_IDLE) begin
        r_acc <= '0;
        r_idx <= '0;
        if (w_any_req) r_grant <= w_pick1 ? 2'b10 : 2'b01;
      end else if (r_word_vld) begin
        r_acc <= w_sum;
      end
      if (r_state == S_FLUSH) r_res_id <= r_grant[1];
      if ((r_state == S_RESULT) && res_ready) begin
        r_grant <= '0;
        r_last  <= r_grant[1];
      end
    end
  end

  assign req0_ready = (r_state == S_RUN) & r_grant[0];
  assign req1_ready = (r_state == S_RUN) & r_grant[1];
  assign grant      = r_grant;
  assign busy       = (r_state != S_IDLE);
  assign res_valid  = (r_state == S_RESULT);
  assign res_data   = r_acc;
  assign res_id     = r_res_id;
endmodule

// File: doc/popcount_frame_scheduler.md
# popcount_frame_scheduler

- Two-requester, round-robin scheduler for the team's shared weighted-popcount accumulator datapath.
- Instantiates `number_of_ones` and `carry_lookahead_adder #(.WIDTH(WIDTH))`.
- Each requester submits frames of exactly four 16-bit words over a valid/ready handshake.
- The block grants one requester at a time, feeds its four words through the accumulator, and returns one tagged result per frame over a valid/ready result port.

## Interface
- `WIDTH`, default 8: accumulator and result width. The result wraps modulo 2^WIDTH.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req0_valid`, input, 1: requester 0 presents a word.
- `req0_data`, input, 16: requester 0 word.
- `req0_ready`, output, 1: requester 0 word accepted this cycle when `req0_valid` is also high.
- `req1_valid`, input, 1: requester 1 presents a word.
- `req1_data`, input, 16: requester 1 word.
- `req1_ready`, output, 1: requester 1 word accepted this cycle when `req1_valid` is also high.
- `grant`, output, 2: one-hot owner of the current frame; 00 when idle.
- `busy`, output, 1: high in every state except IDLE.
- `res_valid`, output, 1: frame result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, WIDTH: frame result.
- `res_id`, output, 1: requester that produced `res_data`.

## Operation
- **Result definition:** `res_data` = Σ over k = 0..3 of (popcount(word_k) << k), modulo 2^WIDTH. word_k is the k-th accepted beat of the frame. Maximum value is 240, so there is no wrap at WIDTH = 8.
- **States:** IDLE, RUN, FLUSH, RESULT.
- **IDLE**
  - Accumulator is cleared and the beat index is 0.
  - If any `reqN_valid` is high, pick a requester and go to RUN. `grant` is set on the same edge.
  - If only one requester is valid, pick it.
  - If both are valid, pick the one not granted last. The last-grant register resets to 1, so requester 0 wins the first tie.
- **RUN**
  - `reqN_ready` = 1 only for the granted requester. The other requester's ready is 0.
  - Each beat (valid & ready):
    - Registers the word together with the current index.
    - Increments the index.
  - In the cycle after a beat, the registered word is added to the accumulator: acc <= acc + (popcount(word_reg) << idx_reg).
  - If `valid` drops mid-frame, the block stalls. Index and accumulator hold. There is no timeout.
  - The 4th beat (index 3) moves the state to FLUSH. Ready deasserts on that same edge.
- **FLUSH:** one cycle, during which the 4th word is accumulated. Then go to RESULT and latch `res_id` = granted requester.
- **RESULT**
  - `res_valid` = 1.
  - `res_data` = accumulator; it and `res_id` are stable until accepted.
  - On `res_valid & res_ready`: go to IDLE, clear `grant`, and update last-grant. Arbitration for the next frame happens in the following cycle.
- **Reset** (asynchronous, any time):
  - State returns to IDLE.
  - Accumulator, index, word register, `res_data`, `res_id` and `grant` are cleared.
  - Last-grant is set to 1. All ready outputs, `res_valid` and `busy` go to 0.
  - A partial frame is discarded. Reset is released synchronously to `clk` by the system.

## Timing
- **Grant:** when a request is seen in IDLE at edge t, `grant` and ready are high after edge t. The first beat can be accepted at edge t+1.
- **Throughput:** with continuous valid, beats are accepted at edges t+1 to t+4.
- **Result latency:**
  - FLUSH occupies the cycle after edge t+4.
  - `res_valid` rises after edge t+5, i.e. 2 cycles after the last beat edge.
- **Back-to-back frames:** when `res_ready` is held high, RESULT lasts 1 cycle. Minimum frame period is 7 cycles: IDLE, 4×RUN, FLUSH, RESULT.
- **No combinational paths** from any input to any output. All outputs are registered or decoded from registered state.

## Test plan
- **Single frame:** requester 0 sends 0xFFFF, 0x0000, 0x0001, 0x0003 contiguously. Require `res_data` = 0x24, `res_id` = 0, `res_valid` 2 cycles after the 4th beat.
- **Maximum value:** requester 1 sends 0xFFFF ×4. Require `res_data` = 0xF0, `res_id` = 1, `req0_ready` = 0 throughout.
- **Arbitration:** both requesters hold valid continuously from reset release with 0x0001 ×4. Require results with `res_id` sequence 0, 1, 0, 1, each `res_data` = 0x0F, and at most 7 cycles between results.
- **Result backpressure:** hold `res_ready` low for 5 cycles in RESULT. Require `res_valid`, `res_data` and `res_id` stable, both readies 0, and no new grant until acceptance.
- **Valid gaps:** insert 3 idle cycles between each beat of the single-frame pattern. Require an identical result, 0x24.
- **Mid-frame reset:** assert `rst` after 2 beats. Require all outputs 0 immediately, without waiting for a clock edge. A subsequent 0x0001 ×4 frame from requester 1 must yield 0x0F with `res_id` = 1. A tie after reset must grant requester 0.
